// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU ops, immediate formats.
// Also holds the D/E bundle and the immediate/ALU helper functions.
package riscv_pkg;

  localparam int XW = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic          valid;
    logic [XW-1:0] pc;
    logic [XW-1:0] rs1_val;
    logic [XW-1:0] rs2_val;
    logic [XW-1:0] imm;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    alu_op_e       alu_op;
    logic          alu_src;
    logic          mem_re;
    logic          mem_we;
    logic [2:0]    mem_size;
    logic          reg_we;
    logic          branch;
    logic          jump;
    logic          illegal;
  } id_ex_t;

  function automatic logic [XW-1:0] imm_gen(
    input logic [31:0] i,
    input imm_fmt_e    f
  );
    logic [XW-1:0] r;
    r = '0;
    unique case (f)
      IMM_I: r = {{21{i[31]}}, i[30:20]};
      IMM_S: r = {{21{i[31]}}, i[30:25], i[11:7]};
      IMM_B: r = {{20{i[31]}}, i[7], i[30:25],
                  i[11:8], 1'b0};
      IMM_U: r = {i[31:12], 12'b0};
      IMM_J: r = {{12{i[31]}}, i[19:12], i[20],
                  i[30:21], 1'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

  // alt selects SUB/SRA; immediates only honour it for shifts.
  function automatic alu_op_e alu_sel(
    input logic [2:0] f3,
    input logic       alt
  );
    alu_op_e r;
    unique case (f3)
      3'd0: r = alt ? ALU_SUB : ALU_ADD;
      3'd1: r = ALU_SLL;
      3'd2: r = ALU_SLT;
      3'd3: r = ALU_SLTU;
      3'd4: r = ALU_XOR;
      3'd5: r = alt ? ALU_SRA : ALU_SRL;
      3'd6: r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch, writeback and D/E signal bundle around the decode stage.
// slave is the decode side, master drives fetch/writeback.
interface decode_stage_if;

  logic [31:0] InstrD;
  logic [31:0] PC_DE;
  logic        FLUSH;
  logic        WB_WE;
  logic [4:0]  WB_RD;
  logic [31:0] WB_DATA;
  logic        STALL_F;
  logic        VALID_E;
  logic [31:0] PC_E;
  logic [31:0] RS1_VAL_E;
  logic [31:0] RS2_VAL_E;
  logic [31:0] IMM_E;
  logic [4:0]  RD_E;
  logic [4:0]  RS1_E;
  logic [4:0]  RS2_E;
  logic [3:0]  ALU_OP_E;
  logic        ALU_SRC_E;
  logic        MEM_RE_E;
  logic        MEM_WE_E;
  logic [2:0]  MEM_SIZE_E;
  logic        REG_WE_E;
  logic        BRANCH_E;
  logic        JUMP_E;
  logic        ILLEGAL_E;

  modport slave (
    input  InstrD, PC_DE, FLUSH,
    input  WB_WE, WB_RD, WB_DATA,
    output STALL_F, VALID_E, PC_E,
    output RS1_VAL_E, RS2_VAL_E, IMM_E,
    output RD_E, RS1_E, RS2_E,
    output ALU_OP_E, ALU_SRC_E,
    output MEM_RE_E, MEM_WE_E, MEM_SIZE_E,
    output REG_WE_E, BRANCH_E, JUMP_E,
    output ILLEGAL_E
  );

  modport master (
    output InstrD, PC_DE, FLUSH,
    output WB_WE, WB_RD, WB_DATA,
    input  STALL_F, VALID_E, PC_E,
    input  RS1_VAL_E, RS2_VAL_E, IMM_E,
    input  RD_E, RS1_E, RS2_E,
    input  ALU_OP_E, ALU_SRC_E,
    input  MEM_RE_E, MEM_WE_E, MEM_SIZE_E,
    input  REG_WE_E, BRANCH_E, JUMP_E,
    input  ILLEGAL_E
  );

endinterface

// File: rtl/reg_file.sv
// 2R1W architectural register file, x0 reads zero.
// Reads see a same-cycle writeback through the bypass.
module reg_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs [NREG];
  logic            wr;

  assign wr = we && (wa != 5'd0);

  // clear on reset, otherwise commit the writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (wr) begin
      regs[wa] <= wd;
    end
  end

  // read ports with x0 forcing and writeback bypass
  always_comb begin
    rd1 = regs[ra1];
    rd2 = regs[ra2];
    if (wr && wa == ra1) rd1 = wd;
    if (wr && wa == ra2) rd2 = wd;
    if (ra1 == 5'd0) rd1 = '0;
    if (ra2 == 5'd0) rd2 = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode: register read, control/immediate decode, D/E register.
// Stalls fetch on load-use and bubbles D/E on stall, flush or reset.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input logic         clk,
  input logic         rst,
  decode_stage_if.slave bus
);

  logic [31:0] ins;
  logic [6:0]  opc;
  logic [4:0]  rs1_f;
  logic [4:0]  rs2_f;
  logic [4:0]  rd_f;
  logic [2:0]  f3;
  logic [XLEN-1:0] v1;
  logic [XLEN-1:0] v2;
  logic        use1;
  logic        use2;
  logic        hz;
  imm_fmt_e    fmt;
  id_ex_t      dec;
  id_ex_t      de;

  assign ins   = bus.InstrD;
  assign opc   = ins[6:0];
  assign rd_f  = ins[11:7];
  assign f3    = ins[14:12];
  assign rs1_f = ins[19:15];
  assign rs2_f = ins[24:20];

  reg_file #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk (clk),
    .rst (rst),
    .we  (bus.WB_WE),
    .wa  (bus.WB_RD),
    .wd  (bus.WB_DATA),
    .ra1 (rs1_f),
    .ra2 (rs2_f),
    .rd1 (v1),
    .rd2 (v2)
  );

  // decode the fetched word into a D/E bundle
  always_comb begin
    dec  = '0;
    fmt  = IMM_R;
    use1 = 1'b0;
    use2 = 1'b0;
    dec.valid = 1'b1;
    dec.pc    = bus.PC_DE;
    unique case (1'b1)
      opc == OP_LUI: begin
        fmt = IMM_U;
        dec.alu_op  = ALU_PASS_B;
        dec.alu_src = 1'b1;
        dec.reg_we  = 1'b1;
      end
      opc == OP_AUIPC: begin
        fmt = IMM_U;
        dec.alu_src = 1'b1;
        dec.reg_we  = 1'b1;
      end
      opc == OP_JAL: begin
        fmt = IMM_J;
        dec.jump   = 1'b1;
        dec.reg_we = 1'b1;
      end
      opc == OP_JALR: begin
        fmt  = IMM_I;
        use1 = 1'b1;
        dec.alu_src = 1'b1;
        dec.jump    = 1'b1;
        dec.reg_we  = 1'b1;
      end
      opc == OP_BRANCH: begin
        fmt  = IMM_B;
        use1 = 1'b1;
        use2 = 1'b1;
        dec.alu_op = ALU_SUB;
        dec.branch = 1'b1;
      end
      opc == OP_LOAD: begin
        fmt  = IMM_I;
        use1 = 1'b1;
        dec.alu_src  = 1'b1;
        dec.mem_re   = 1'b1;
        dec.mem_size = f3;
        dec.reg_we   = 1'b1;
      end
      opc == OP_STORE: begin
        fmt  = IMM_S;
        use1 = 1'b1;
        use2 = 1'b1;
        dec.alu_src  = 1'b1;
        dec.mem_we   = 1'b1;
        dec.mem_size = f3;
      end
      opc == OP_IMM: begin
        fmt  = IMM_I;
        use1 = 1'b1;
        dec.alu_op  = alu_sel(f3,
                        ins[30] && f3 == 3'd5);
        dec.alu_src = 1'b1;
        dec.reg_we  = 1'b1;
      end
      opc == OP_REG: begin
        use1 = 1'b1;
        use2 = 1'b1;
        dec.alu_op = alu_sel(f3, ins[30]);
        dec.reg_we = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.imm     = imm_gen(ins, fmt);
    dec.rd      = dec.reg_we ? rd_f : 5'd0;
    dec.rs1     = use1 ? rs1_f : 5'd0;
    dec.rs2     = use2 ? rs2_f : 5'd0;
    dec.rs1_val = v1;
    dec.rs2_val = v2;
  end

  // load in E whose result a used source of D needs
  always_comb begin
    hz = de.valid && de.mem_re && de.rd != 5'd0
      && ((use1 && de.rd == rs1_f)
       || (use2 && de.rd == rs2_f));
  end

  assign bus.STALL_F = hz && !bus.FLUSH && !rst;

  // D/E pipeline register, bubble on reset/flush/stall
  always_ff @(posedge clk) begin
    if (rst || bus.FLUSH || hz) de <= '0;
    else                        de <= dec;
  end

  assign bus.VALID_E    = de.valid;
  assign bus.PC_E       = de.pc;
  assign bus.RS1_VAL_E  = de.rs1_val;
  assign bus.RS2_VAL_E  = de.rs2_val;
  assign bus.IMM_E      = de.imm;
  assign bus.RD_E       = de.rd;
  assign bus.RS1_E      = de.rs1;
  assign bus.RS2_E      = de.rs2;
  assign bus.ALU_OP_E   = de.alu_op;
  assign bus.ALU_SRC_E  = de.alu_src;
  assign bus.MEM_RE_E   = de.mem_re;
  assign bus.MEM_WE_E   = de.mem_we;
  assign bus.MEM_SIZE_E = de.mem_size;
  assign bus.REG_WE_E   = de.reg_we;
  assign bus.BRANCH_E   = de.branch;
  assign bus.JUMP_E     = de.jump;
  assign bus.ILLEGAL_E  = de.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage.
// Expected D/E contents are queued on drive and popped after the edge.
module tb_decode_stage;
  import riscv_pkg::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  decode_stage_if bus();

  decode_stage u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [3:0]  alu;
    logic        src;
    logic        we;
    logic        re;
    logic        wr;
    logic [2:0]  size;
    logic        ill;
    logic        br;
    logic        jmp;
  } exp_t;

  exp_t q[$];

  localparam logic [3:0] A_ADD = 4'(ALU_ADD);
  localparam logic [3:0] A_SUB = 4'(ALU_SUB);
  localparam logic [3:0] A_PB  = 4'(ALU_PASS_B);
  localparam logic [31:0] ADDI5 = 32'h0050_0093;
  localparam logic [31:0] ADD3  = 32'h0021_01B3;
  localparam logic [31:0] LW2   = 32'h0000_A103;
  localparam logic [31:0] BEEF  = 32'hDEAD_BEEF;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  function automatic exp_t bub();
    exp_t e;
    e = '{default: '0};
    return e;
  endfunction

  function automatic exp_t mk(
    input logic [31:0] pc,
    input logic [4:0]  rd,
    input logic [31:0] imm,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] v1,
    input logic [31:0] v2,
    input logic [3:0]  alu,
    input logic        src,
    input logic        we
  );
    exp_t e;
    e = bub();
    e.valid = 1'b1;
    e.pc  = pc;
    e.rd  = rd;
    e.imm = imm;
    e.rs1 = rs1;
    e.rs2 = rs2;
    e.v1  = v1;
    e.v2  = v2;
    e.alu = alu;
    e.src = src;
    e.we  = we;
    return e;
  endfunction

  task automatic compare();
    exp_t e;
    if (q.size() == 0) begin
      chk("queue_empty", 32'd1, 32'd0);
      return;
    end
    e = q.pop_front();
    chk("valid", 32'(bus.VALID_E), 32'(e.valid));
    chk("pc", bus.PC_E, e.pc);
    chk("imm", bus.IMM_E, e.imm);
    chk("rs1_val", bus.RS1_VAL_E, e.v1);
    chk("rs2_val", bus.RS2_VAL_E, e.v2);
    chk("rd", 32'(bus.RD_E), 32'(e.rd));
    chk("rs1", 32'(bus.RS1_E), 32'(e.rs1));
    chk("rs2", 32'(bus.RS2_E), 32'(e.rs2));
    chk("alu_op", 32'(bus.ALU_OP_E), 32'(e.alu));
    chk("alu_src", 32'(bus.ALU_SRC_E), 32'(e.src));
    chk("reg_we", 32'(bus.REG_WE_E), 32'(e.we));
    chk("mem_re", 32'(bus.MEM_RE_E), 32'(e.re));
    chk("mem_we", 32'(bus.MEM_WE_E), 32'(e.wr));
    chk("mem_size", 32'(bus.MEM_SIZE_E), 32'(e.size));
    chk("illegal", 32'(bus.ILLEGAL_E), 32'(e.ill));
    chk("branch", 32'(bus.BRANCH_E), 32'(e.br));
    chk("jump", 32'(bus.JUMP_E), 32'(e.jmp));
  endtask

  task automatic step(
    input logic [31:0] ins,
    input logic [31:0] pc,
    input logic        fl,
    input logic        we,
    input logic [4:0]  wrd,
    input logic [31:0] wd,
    input logic        stl,
    input exp_t        e
  );
    bus.InstrD  = ins;
    bus.PC_DE   = pc;
    bus.FLUSH   = fl;
    bus.WB_WE   = we;
    bus.WB_RD   = wrd;
    bus.WB_DATA = wd;
    #1;
    chk("stall_f", 32'(bus.STALL_F), 32'(stl));
    q.push_back(e);
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    exp_t e;
    n_chk  = 0;
    n_fail = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;

    step(ADDI5, 32'h100, 0, 0, 0, 0, 0, bub());
    step(ADDI5, 32'h100, 0, 0, 0, 0, 0, bub());
    rst = 1'b0;

    step(ADDI5, 32'h100, 0, 0, 0, 0, 0,
      mk(32'h100, 1, 5, 0, 0, 0, 0, A_ADD, 1, 1));
    step(32'hFFF0_0093, 32'h104, 0, 0, 0, 0, 0,
      mk(32'h104, 1, 32'hFFFF_FFFF, 0, 0, 0, 0,
         A_ADD, 1, 1));

    step(ADD3, 32'h108, 0, 1, 2, BEEF, 0,
      mk(32'h108, 3, 0, 2, 2, BEEF, BEEF, A_ADD, 0, 1));
    step(ADD3, 32'h10C, 0, 0, 0, 0, 0,
      mk(32'h10C, 3, 0, 2, 2, BEEF, BEEF, A_ADD, 0, 1));

    step(32'h0000_0013, 32'h110, 0, 1, 0, 7, 0,
      mk(32'h110, 0, 0, 0, 0, 0, 0, A_ADD, 1, 1));
    step(32'h0000_01B3, 32'h114, 0, 0, 0, 0, 0,
      mk(32'h114, 3, 0, 0, 0, 0, 0, A_ADD, 0, 1));

    e = mk(32'h118, 0, 32'hFFFF_FFFC, 1, 2, 0, BEEF,
           A_ADD, 1, 0);
    e.wr = 1'b1;
    e.size = 3'd2;
    step(32'hFE20_AE23, 32'h118, 0, 0, 0, 0, 0, e);

    step(32'h1234_52B7, 32'h11C, 0, 0, 0, 0, 0,
      mk(32'h11C, 5, 32'h1234_5000, 0, 0, 0, 0,
         A_PB, 1, 1));

    e = mk(32'h120, 2, 0, 1, 0, 0, 0, A_ADD, 1, 1);
    e.re = 1'b1;
    e.size = 3'd2;
    step(LW2, 32'h120, 0, 0, 0, 0, 0, e);
    step(ADD3, 32'h124, 0, 0, 0, 0, 1, bub());
    step(ADD3, 32'h124, 0, 0, 0, 0, 0,
      mk(32'h124, 3, 0, 2, 2, BEEF, BEEF, A_ADD, 0, 1));

    e.pc = 32'h128;
    step(LW2, 32'h128, 0, 0, 0, 0, 0, e);
    step(ADD3, 32'h12C, 1, 0, 0, 0, 0, bub());
    step(ADD3, 32'h12C, 0, 0, 0, 0, 0,
      mk(32'h12C, 3, 0, 2, 2, BEEF, BEEF, A_ADD, 0, 1));

    step(32'hFFFF_FFFF, 32'h200, 1, 0, 0, 0, 0, bub());
    e = bub();
    e.valid = 1'b1;
    e.pc = 32'h204;
    e.ill = 1'b1;
    step(32'hFFFF_FFFF, 32'h204, 0, 0, 0, 0, 0, e);

    e = mk(32'h208, 2, 0, 1, 0, 0, 0, A_ADD, 1, 1);
    e.re = 1'b1;
    e.size = 3'd2;
    step(LW2, 32'h208, 0, 0, 0, 0, 0, e);
    rst = 1'b1;
    step(ADD3, 32'h20C, 0, 0, 0, 0, 0, bub());
    rst = 1'b0;
    step(ADD3, 32'h300, 0, 0, 0, 0, 0,
      mk(32'h300, 3, 0, 2, 2, 0, 0, A_ADD, 0, 1));

    e = mk(32'h304, 1, 8, 0, 0, 0, 0, A_ADD, 0, 1);
    e.jmp = 1'b1;
    step(32'h0080_00EF, 32'h304, 0, 0, 0, 0, 0, e);

    e = mk(32'h308, 0, 32'hFFFF_FFFC, 1, 2, 0, 0,
           A_SUB, 0, 0);
    e.br = 1'b1;
    step(32'hFE20_8EE3, 32'h308, 0, 0, 0, 0, 0, e);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV32I decode stage, directly downstream of the fetch stage.
- Consumes InstrD/PC_DE from fetch, reads a 32x32 register file and decodes control and immediate.
- Registers results into the D/E pipeline register feeding execute.
- Detects load-use hazards: stalls fetch and inserts a bubble. Honours a flush from execute on redirect.

Parameters:
- XLEN, 32, datapath and register width
- NREG, 32, architectural registers; x0 hardwired to zero

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- InstrD  in  32  instruction word from fetch
- PC_DE  in  32  PC of InstrD
- FLUSH  in  1  execute redirect (same cycle as fetch PC_R); kill the decoding instruction
- WB_WE  in  1  writeback register write enable
- WB_RD  in  5  writeback destination
- WB_DATA  in  32  writeback value
- STALL_F  out  1  hold fetch PC and InstrD this cycle (combinational)
- VALID_E  out  1  D/E slot holds a real instruction
- PC_E  out  32  PC of instruction in E
- RS1_VAL_E, RS2_VAL_E  out  32 each  source operand values
- IMM_E  out  32  sign-extended immediate
- RD_E  out  5  destination register
- RS1_E, RS2_E  out  5 each  source indices, for execute forwarding
- ALU_OP_E  out  4  ALU operation code (package enum)
- ALU_SRC_E  out  1  0 = RS2 value, 1 = IMM
- MEM_RE_E, MEM_WE_E  out  1 each  load / store
- MEM_SIZE_E  out  3  funct3 for load/store
- REG_WE_E  out  1  writes RD
- BRANCH_E, JUMP_E  out  1 each  conditional branch / JAL-JALR
- ILLEGAL_E  out  1  unknown opcode decoded

Behaviour:
- Reset (rst=1 at edge): all *_E outputs 0; VALID_E=0; all registers 0. STALL_F=0 while rst=1.
- Latency: 1 cycle. Instruction on InstrD at edge N appears on *_E after edge N with VALID_E=1.
- Immediate formats: I, S, B, U, J per RV32I, all sign-extended from instr[31]. R-type IMM_E=0.
- Register file:
  - Two combinational read ports, one write port.
  - Write on edge when WB_WE=1 and WB_RD!=0. Writes to x0 are ignored; reads of x0 return 0.
  - Same-cycle bypass: if WB_WE=1, WB_RD!=0 and WB_RD equals rs1 (or rs2), the read returns WB_DATA.
- Source usage:
  - rs1 is used by all opcodes except LUI, AUIPC, JAL.
  - rs2 is used by R-type, STORE, BRANCH.
  - Unused source fields are still forwarded, with RS*_E=0 so execute never forwards on them.
- Load-use hazard: STALL_F=1 when VALID_E=1, MEM_RE_E=1, RD_E!=0, and RD_E matches a used source of InstrD. On that edge, D/E loads a bubble (all control 0, VALID_E=0); fetch holds. Next cycle the hazard is gone and the instruction issues normally.
- Flush: FLUSH=1 at edge makes D/E load a bubble, and STALL_F is forced to 0.
  - FLUSH overrides stall.
  - Register file writes still happen.
- Illegal opcode: ILLEGAL_E=1, VALID_E=1, REG_WE_E=MEM_RE_E=MEM_WE_E=BRANCH_E=JUMP_E=0.
- NOP (0x00000013) decodes as a normal ADDI x0 with REG_WE_E=1. Execute/writeback drop x0 writes.
- No internal state machine beyond the D/E register. The stall is a one-cycle condition re-evaluated every cycle.
- rst mid-stream: bubble D/E, clear register file, STALL_F=0.

Decomposition:
- Shared package riscv_pkg:
  - opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG)
  - ALU_OP enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B)
  - immediate-format enum
- One sub-module, reg_file: 2R1W, x0 zero, write bypass, synchronous reset.
- Decoder, hazard logic and D/E register stay in decode_stage.

Test Plan:
- Reset: hold rst 2 cycles with InstrD=0x00500093 -> VALID_E=0, all *_E=0, STALL_F=0. Release -> next edge VALID_E=1, PC_E=PC_DE, RD_E=1, IMM_E=5, ALU_SRC_E=1, ALU_OP_E=ADD, REG_WE_E=1.
- Immediate sign: InstrD=0xFFF00093 -> IMM_E=0xFFFFFFFF.
- Writeback bypass: WB_WE=1, WB_RD=2, WB_DATA=0xDEADBEEF in the same cycle as InstrD=0x002101B3 -> RS1_VAL_E=RS2_VAL_E=0xDEADBEEF. A following read of x2 returns the same value from the array.
- x0 write: WB_WE=1, WB_RD=0, WB_DATA=7, then read x0 -> 0.
- Load-use: InstrD=0x0000A103 (lw x2) then 0x002101B3 (add x3,x2,x2):
  - the second cycle gives STALL_F=1, and the next edge loads a bubble (VALID_E=0);
  - the following edge issues the add with RD_E=3.
- Flush over stall: repeat the load-use case with FLUSH=1 in the stall cycle -> STALL_F=0, VALID_E=0 after the edge. Flush with an illegal word 0xFFFFFFFF -> ILLEGAL_E stays 0.
